// File: rtl/riscv_fd_pkg.sv
// Shared types for the fetch/decode boundary: the queued entry format and the pc step helper.
package riscv_fd_pkg;

  localparam int unsigned RISCV_FD_XLEN       = 64;
  localparam logic [15:0] RISCV_FD_CINST_NONE = 16'h0000;

  typedef struct packed {
    logic [RISCV_FD_XLEN-1:0] pc;
    logic [RISCV_FD_XLEN-1:0] pcplus4;
    logic [31:0]              inst;
    logic [15:0]              cinst;
  } fd_entry_t;

  // Sequential pc increment: 2 for a compressed instruction, 4 otherwise.
  function automatic logic [RISCV_FD_XLEN-1:0] fd_pc_step(input logic iscomp);
    return {{(RISCV_FD_XLEN-3){1'b0}}, ~iscomp, iscomp, 1'b0};
  endfunction

endpackage

// File: rtl/riscv_fd_fifo.sv
// Skid FIFO for the fetch/decode boundary: DEPTH x fd_entry_t circular buffer, clear wins over push/pop.
module riscv_fd_fifo
  import riscv_fd_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  fd_entry_t     wdata_i,
  output fd_entry_t     rdata_o,
  output logic [CW-1:0] count_o,
  output logic          empty_o
);

  fd_entry_t     mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full, do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A push into a full buffer is only legal when the same cycle pops.
  assign do_push = push_i & ~clear_i & (~full | pop_i);
  assign do_pop  = pop_i & ~clear_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/riscv_ppreg_fd.sv
// Fetch/decode pipeline register with skid FIFO, bypass path and flush/stall control.
// Optional bubble counter enabled by defining RISCV_FD_BUBBLE_CNT_EN.
module riscv_ppreg_fd
  import riscv_fd_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned XLEN  = 64
) (
  input  logic            i_riscv_fd_clk,
  input  logic            i_riscv_fd_rst_n,
  input  logic            i_riscv_fd_flush,
  input  logic            i_riscv_fd_stall,
  input  logic            i_riscv_fd_valid_f,
  output logic            o_riscv_fd_ready_f,
  input  logic [XLEN-1:0] i_riscv_fd_pc_f,
  input  logic [31:0]     i_riscv_fd_inst_f,
  input  logic [15:0]     i_riscv_fd_cinst_f,
  input  logic            i_riscv_fd_iscomp_f,
  output logic            o_riscv_fd_valid_d,
  output logic [XLEN-1:0] o_riscv_fd_pc_d,
  output logic [XLEN-1:0] o_riscv_fd_pcplus4_d,
  output logic [31:0]     o_riscv_fd_inst_d,
  output logic [15:0]     o_riscv_fd_cinst_d,
  output logic [31:0]     o_riscv_fd_bubbles
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  fd_entry_t     in_entry, head_entry, out_q, out_d;
  logic          valid_q, valid_d;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty, xfer, fifo_push, fifo_pop;

  // ready depends only on the registered occupancy.
  assign o_riscv_fd_ready_f = (fifo_count < CW'(DEPTH));
  assign xfer               = i_riscv_fd_valid_f & o_riscv_fd_ready_f;

  // pc is held zero-extended; truncating at the outputs gives wrap modulo 2^XLEN.
  always_comb begin
    in_entry.pc      = RISCV_FD_XLEN'(i_riscv_fd_pc_f);
    in_entry.pcplus4 = in_entry.pc + fd_pc_step(i_riscv_fd_iscomp_f);
    in_entry.inst    = i_riscv_fd_inst_f;
    in_entry.cinst   = i_riscv_fd_iscomp_f ? i_riscv_fd_cinst_f : RISCV_FD_CINST_NONE;
  end

  assign fifo_push = ~i_riscv_fd_flush & xfer & (i_riscv_fd_stall | ~fifo_empty);
  assign fifo_pop  = ~i_riscv_fd_flush & ~i_riscv_fd_stall & ~fifo_empty;

  riscv_fd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (i_riscv_fd_clk),
    .rst_n   (i_riscv_fd_rst_n),
    .clear_i (i_riscv_fd_flush),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (in_entry),
    .rdata_o (head_entry),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

  always_comb begin
    out_d   = out_q;
    valid_d = valid_q;
    if (i_riscv_fd_flush) begin
      out_d   = '0;
      valid_d = 1'b0;
    end else if (!i_riscv_fd_stall) begin
      if (!fifo_empty) begin
        out_d   = head_entry;
        valid_d = 1'b1;
      end else if (xfer) begin
        out_d   = in_entry;
        valid_d = 1'b1;
      end else begin
        out_d   = '0;
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge i_riscv_fd_clk or negedge i_riscv_fd_rst_n) begin
    if (!i_riscv_fd_rst_n) begin
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign o_riscv_fd_valid_d   = valid_q;
  assign o_riscv_fd_pc_d      = out_q.pc[XLEN-1:0];
  assign o_riscv_fd_pcplus4_d = out_q.pcplus4[XLEN-1:0];
  assign o_riscv_fd_inst_d    = out_q.inst;
  assign o_riscv_fd_cinst_d   = out_q.cinst;

`ifdef RISCV_FD_BUBBLE_CNT_EN
  logic [31:0] bubbles_q;
  logic        bubble_evt;

  assign bubble_evt = i_riscv_fd_flush | (~i_riscv_fd_stall & fifo_empty & ~xfer);

  always_ff @(posedge i_riscv_fd_clk or negedge i_riscv_fd_rst_n) begin
    if (!i_riscv_fd_rst_n) bubbles_q <= '0;
    else if (bubble_evt)   bubbles_q <= bubbles_q + 32'd1;
  end

  assign o_riscv_fd_bubbles = bubbles_q;
`else
  assign o_riscv_fd_bubbles = '0;
`endif

endmodule

// File: tb/tb_riscv_ppreg_fd.sv
// Self-checking bench for riscv_ppreg_fd: vector table, directed corner sequences, randomized run vs queue model.
module tb_riscv_ppreg_fd;

  localparam int DEPTH = 2;
  localparam int XLEN  = 64;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush, stall, valid_f, iscomp_f;
  logic            ready_f, valid_d;
  logic [XLEN-1:0] pc_f, pc_d, pcplus4_d;
  logic [31:0]     inst_f, inst_d, bubbles;
  logic [15:0]     cinst_f, cinst_d;

  int checks = 0;
  int errors = 0;

  riscv_ppreg_fd #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .i_riscv_fd_clk       (clk),
    .i_riscv_fd_rst_n     (rst_n),
    .i_riscv_fd_flush     (flush),
    .i_riscv_fd_stall     (stall),
    .i_riscv_fd_valid_f   (valid_f),
    .o_riscv_fd_ready_f   (ready_f),
    .i_riscv_fd_pc_f      (pc_f),
    .i_riscv_fd_inst_f    (inst_f),
    .i_riscv_fd_cinst_f   (cinst_f),
    .i_riscv_fd_iscomp_f  (iscomp_f),
    .o_riscv_fd_valid_d   (valid_d),
    .o_riscv_fd_pc_d      (pc_d),
    .o_riscv_fd_pcplus4_d (pcplus4_d),
    .o_riscv_fd_inst_d    (inst_d),
    .o_riscv_fd_cinst_d   (cinst_d),
    .o_riscv_fd_bubbles   (bubbles)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1);
  end

  typedef struct {
    logic        valid;
    logic [63:0] pc;
    logic [31:0] inst;
    logic [15:0] cinst;
    logic        iscomp;
    logic        exp_valid;
    logic [63:0] exp_pc;
    logic [63:0] exp_p4;
    logic [31:0] exp_inst;
    logic [15:0] exp_cinst;
  } vec_t;

  typedef struct {
    logic [63:0] pc;
    logic [63:0] p4;
    logic [31:0] inst;
    logic [15:0] cinst;
  } ment_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [63:0] pc,
                         input logic [63:0] p4, input logic [31:0] inst, input logic [15:0] cinst);
    chk({tag, " valid_d"}, 64'(valid_d), 64'(v));
    chk({tag, " pc_d"}, pc_d, pc);
    chk({tag, " pcplus4_d"}, pcplus4_d, p4);
    chk({tag, " inst_d"}, 64'(inst_d), 64'(inst));
    chk({tag, " cinst_d"}, 64'(cinst_d), 64'(cinst));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic f, input logic s, input logic v, input logic [63:0] pc, input logic comp);
    flush    = f;
    stall    = s;
    valid_f  = v;
    pc_f     = pc;
    iscomp_f = comp;
    inst_f   = pc[31:0] ^ 32'h0000_0013;
    cinst_f  = comp ? 16'h4501 : 16'h0000;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  vec_t  vecs [6];
  ment_t mq [$];
  ment_t mout, ent;
  logic  mvalid, mready, mxfer;
  logic  [31:0] mbub, exp_bub;
  logic  [63:0] rpc;

  initial begin
    // Directed vectors starting from an empty, idle block.
    vecs[0] = '{1'b1, 64'h1000, 32'h0000_0013, 16'h0000, 1'b0, 1'b1, 64'h1000, 64'h1004, 32'h0000_0013, 16'h0000};
    vecs[1] = '{1'b1, 64'h1004, 32'h00a0_0513, 16'h4501, 1'b1, 1'b1, 64'h1004, 64'h1006, 32'h00a0_0513, 16'h4501};
    vecs[2] = '{1'b0, 64'h0,    32'h0,         16'h0000, 1'b0, 1'b0, 64'h0,    64'h0,    32'h0,         16'h0000};
    vecs[3] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 32'h0000_0093, 16'h0000, 1'b0,
                1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 32'h0000_0093, 16'h0000};
    vecs[4] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 32'h0000_0013, 16'h0001, 1'b1,
                1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0, 32'h0000_0013, 16'h0001};
    vecs[5] = '{1'b0, 64'h0,    32'h0,         16'h0000, 1'b0, 1'b0, 64'h0,    64'h0,    32'h0,         16'h0000};

    set_in(1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
    rst_n = 1'b0;
    repeat (2) tick();
    chk_out("reset", 1'b0, 64'h0, 64'h0, 32'h0, 16'h0);
    chk("reset bubbles", 64'(bubbles), 64'h0);
    rst_n = 1'b1;
    chk("reset ready_f", 64'(ready_f), 64'h1);

    // Bypass vectors, including pcplus4 wrap at the top of the address space.
    for (int i = 0; i < 6; i++) begin
      flush = 1'b0; stall = 1'b0;
      valid_f = vecs[i].valid; pc_f = vecs[i].pc; inst_f = vecs[i].inst;
      cinst_f = vecs[i].cinst; iscomp_f = vecs[i].iscomp;
      chk($sformatf("vec%0d ready_f", i), 64'(ready_f), 64'h1);
      tick();
      chk_out($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_pc, vecs[i].exp_p4,
              vecs[i].exp_inst, vecs[i].exp_cinst);
      $display("vec%0d pc_f=%h -> valid_d=%0d pc_d=%h pcplus4_d=%h", i, vecs[i].pc, valid_d, pc_d, pcplus4_d);
    end

    // Stall 3 cycles with fetch pushing: two queued, third held off, then in-order delivery.
    set_in(1'b0, 1'b1, 1'b1, 64'h2000, 1'b0);
    chk("stall push0 ready_f", 64'(ready_f), 64'h1);
    tick();
    chk("stall hold valid_d", 64'(valid_d), 64'h0);
    set_in(1'b0, 1'b1, 1'b1, 64'h2004, 1'b0);
    chk("stall push1 ready_f", 64'(ready_f), 64'h1);
    tick();
    set_in(1'b0, 1'b1, 1'b1, 64'h2008, 1'b0);
    chk("stall full ready_f", 64'(ready_f), 64'h0);
    tick();
    chk("stall full2 ready_f", 64'(ready_f), 64'h0);
    set_in(1'b0, 1'b0, 1'b1, 64'h2008, 1'b0);
    tick();
    chk_out("drain0", 1'b1, 64'h2000, 64'h2004, 32'h2013, 16'h0);
    chk("drain0 ready_f", 64'(ready_f), 64'h1);
    tick();
    chk_out("drain1", 1'b1, 64'h2004, 64'h2008, 32'h2017, 16'h0);
    set_in(1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
    tick();
    chk_out("drain2", 1'b1, 64'h2008, 64'h200C, 32'h201B, 16'h0);
    tick();
    chk_out("drain3", 1'b0, 64'h0, 64'h0, 32'h0, 16'h0);
    $display("stall sequence done, ready_f=%0d", ready_f);

    // Flush while stalled with a full FIFO and fetch still presenting.
    set_in(1'b0, 1'b0, 1'b1, 64'h20F0, 1'b0);
    tick();
    set_in(1'b0, 1'b1, 1'b1, 64'h2100, 1'b0);
    tick();
    set_in(1'b0, 1'b1, 1'b1, 64'h2104, 1'b0);
    tick();
    chk("preflush ready_f", 64'(ready_f), 64'h0);
    chk("preflush valid_d", 64'(valid_d), 64'h1);
    set_in(1'b1, 1'b1, 1'b1, 64'h2108, 1'b0);
    tick();
    chk_out("flush", 1'b0, 64'h0, 64'h0, 32'h0, 16'h0);
    chk("flush ready_f", 64'(ready_f), 64'h1);
    set_in(1'b0, 1'b0, 1'b1, 64'h3000, 1'b0);
    tick();
    chk_out("postflush", 1'b1, 64'h3000, 64'h3004, 32'h3013, 16'h0);
    set_in(1'b1, 1'b0, 1'b1, 64'h3100, 1'b0);
    tick();
    chk_out("flush discard", 1'b0, 64'h0, 64'h0, 32'h0, 16'h0);
    set_in(1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
    tick();
    chk_out("flush nostale", 1'b0, 64'h0, 64'h0, 32'h0, 16'h0);
    $display("flush sequence done, valid_d=%0d", valid_d);

    // Asynchronous reset mid-cycle with two entries queued.
    set_in(1'b0, 1'b0, 1'b1, 64'h5000, 1'b0);
    tick();
    set_in(1'b0, 1'b1, 1'b1, 64'h5004, 1'b0);
    tick();
    set_in(1'b0, 1'b1, 1'b1, 64'h5008, 1'b1);
    tick();
    chk("prereset ready_f", 64'(ready_f), 64'h0);
    chk("prereset valid_d", 64'(valid_d), 64'h1);
    set_in(1'b0, 1'b1, 1'b0, 64'h0, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk_out("async reset", 1'b0, 64'h0, 64'h0, 32'h0, 16'h0);
    tick();
    rst_n = 1'b1;
    stall = 1'b0;
    chk("postreset ready_f", 64'(ready_f), 64'h1);
    tick();
    chk_out("postreset0", 1'b0, 64'h0, 64'h0, 32'h0, 16'h0);
    tick();
    chk_out("postreset1", 1'b0, 64'h0, 64'h0, 32'h0, 16'h0);
    $display("async reset sequence done");

    // Bubble counter: 5 idle advances + 1 flush + 4 stalls.
    set_in(1'b0, 1'b1, 1'b0, 64'h0, 1'b0);
    do_reset();
    chk("bubbles after reset", 64'(bubbles), 64'h0);
    stall = 1'b0;
    repeat (5) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0; stall = 1'b1;
    repeat (4) tick();
`ifdef RISCV_FD_BUBBLE_CNT_EN
    chk("bubbles count", 64'(bubbles), 64'd6);
`else
    chk("bubbles count", 64'(bubbles), 64'd0);
`endif
    $display("bubble counter = %0d", bubbles);

    // Randomized run against a queue model of in-order delivery.
    set_in(1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
    do_reset();
    mq.delete();
    mout = '{64'h0, 64'h0, 32'h0, 16'h0};
    mvalid = 1'b0;
    mbub = 32'h0;
    for (int n = 0; n < 400; n++) begin
      rpc = {$urandom, $urandom} & ~64'h1;
      if ($urandom_range(0, 9) == 0) rpc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 7) << 1);
      set_in(($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 6),
             rpc, $urandom_range(0, 1) == 1);
      mready = (mq.size() < DEPTH);
      chk($sformatf("rnd%0d ready_f", n), 64'(ready_f), 64'(mready));
      mxfer = valid_f & mready;
      ent.pc    = pc_f;
      ent.p4    = pc_f + (iscomp_f ? 64'd2 : 64'd4);
      ent.inst  = inst_f;
      ent.cinst = iscomp_f ? cinst_f : 16'h0;
      if (flush) begin
        mq.delete();
        mvalid = 1'b0;
        mout = '{64'h0, 64'h0, 32'h0, 16'h0};
        mbub++;
      end else if (stall) begin
        if (mxfer) mq.push_back(ent);
      end else begin
        if (mxfer) mq.push_back(ent);
        if (mq.size() > 0) begin
          mout = mq.pop_front();
          mvalid = 1'b1;
        end else begin
          mvalid = 1'b0;
          mout = '{64'h0, 64'h0, 32'h0, 16'h0};
          mbub++;
        end
      end
      tick();
      chk_out($sformatf("rnd%0d", n), mvalid, mout.pc, mout.p4, mout.inst, mout.cinst);
`ifdef RISCV_FD_BUBBLE_CNT_EN
      exp_bub = mbub;
`else
      exp_bub = 32'h0;
`endif
      chk($sformatf("rnd%0d bubbles", n), 64'(bubbles), 64'(exp_bub));
      if (mvalid) $display("rnd%0d deliver pc=%h pcplus4=%h", n, pc_d, pcplus4_d);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
